// File: rtl/mc_alu_pkg.sv
// Shared definitions for mc_alu: operation encodings and FSM state type.
package mc_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_DIVU = 4'b1100,
    OP_REMU = 4'b1101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/mc_alu_iter.sv
// Iterative datapath for mc_alu: shift-add multiply and, with MC_ALU_DIV_EN,
// unsigned restoring divide. One iteration per step; last flags the final one.
module mc_alu_iter
  import mc_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
`ifdef MC_ALU_DIV_EN
  input  logic             div,
  output logic [WIDTH-1:0] quo_next,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] acc_next
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  // acc: product / partial remainder; md: multiplicand / divisor; mq: multiplier / quotient
  logic [WIDTH-1:0] acc, md, mq;
  logic [WIDTH-1:0] acc_n, md_n, mq_n;
  logic [CW-1:0]    cnt;

`ifdef MC_ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   sh;
`endif

  always_comb begin
    acc_n = acc;
    md_n  = md;
    mq_n  = mq;
`ifdef MC_ALU_DIV_EN
    sh = {acc, mq[WIDTH-1]};
    if (div_q) begin
      if (sh >= {1'b0, md}) begin
        acc_n = WIDTH'(sh - {1'b0, md});
        mq_n  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = sh[WIDTH-1:0];
        mq_n  = {mq[WIDTH-2:0], 1'b0};
      end
    end else
`endif
    begin
      if (mq[0]) acc_n = acc + md;
      md_n = md << 1;
      mq_n = mq >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      md  <= '0;
      mq  <= '0;
      cnt <= '0;
`ifdef MC_ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (load) begin
      acc <= '0;
      cnt <= '0;
`ifdef MC_ALU_DIV_EN
      div_q <= div;
      md    <= div ? b : a;
      mq    <= div ? a : b;
`else
      md    <= a;
      mq    <= b;
`endif
    end else if (step) begin
      acc <= acc_n;
      md  <= md_n;
      mq  <= mq_n;
      cnt <= cnt + 1'b1;
    end
  end

  assign last     = (cnt == CW'(WIDTH - 1));
  assign acc_next = acc_n;
`ifdef MC_ALU_DIV_EN
  assign quo_next = mq_n;
`endif

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative MUL and (with
// MC_ALU_DIV_EN defined) DIVU/REMU. Without the macro DIVU/REMU act as unlisted ops.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  state_e           state, state_n;
  logic             load, step, upd, known;
  logic [WIDTH-1:0] y_n;
  logic             c_n, v_n, dz_n;
  logic             last;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic             slt;

  assign b_eff   = (op == OP_SUB) ? ~b : b;
  assign sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
  assign slt     = $signed(a) < $signed(b);

`ifdef MC_ALU_DIV_EN
  logic             iter_div, run_div, run_rem, dz_q;
  logic [WIDTH-1:0] quo_next;
  assign iter_div = (op == OP_DIVU) || (op == OP_REMU);
`endif

  mc_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
`ifdef MC_ALU_DIV_EN
    .div      (iter_div),
    .quo_next (quo_next),
`endif
    .a        (a),
    .b        (b),
    .last     (last),
    .acc_next (acc_next)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    upd     = 1'b0;
    known   = 1'b1;
    y_n     = '0;
    c_n     = 1'b0;
    v_n     = 1'b0;
    dz_n    = 1'b0;
    unique case (state)
      S_IDLE: if (start) begin
        upd     = 1'b1;
        state_n = S_DONE;
        case (op)
          OP_AND: y_n = a & b;
          OP_OR:  y_n = a | b;
          OP_ADD, OP_SUB: begin
            y_n = sum_ext[WIDTH-1:0];
            c_n = sum_ext[WIDTH];
            v_n = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
          end
          OP_SLT: y_n[0] = slt;
          OP_MUL: begin
            upd     = 1'b0;
            load    = 1'b1;
            state_n = S_RUN;
          end
`ifdef MC_ALU_DIV_EN
          OP_DIVU, OP_REMU: begin
            if (b == '0) begin
              y_n  = (op == OP_DIVU) ? '1 : a;
              dz_n = 1'b1;
            end else begin
              upd     = 1'b0;
              load    = 1'b1;
              state_n = S_RUN;
            end
          end
`endif
          default: known = 1'b0;
        endcase
      end
      S_RUN: begin
        step = 1'b1;
        if (last) begin
          upd     = 1'b1;
          state_n = S_DONE;
`ifdef MC_ALU_DIV_EN
          y_n = (run_div && !run_rem) ? quo_next : acc_next;
`else
          y_n = acc_next;
`endif
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      y        <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
`ifdef MC_ALU_DIV_EN
      dz_q    <= 1'b0;
      run_div <= 1'b0;
      run_rem <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (upd) begin
        y        <= y_n;
        // unlisted ops clear every flag, including zero
        zero     <= known && (y_n == '0);
        negative <= known && y_n[WIDTH-1];
        carry    <= c_n;
        overflow <= v_n;
`ifdef MC_ALU_DIV_EN
        dz_q <= dz_n;
`endif
      end
`ifdef MC_ALU_DIV_EN
      if (load) begin
        run_div <= iter_div;
        run_rem <= (op == OP_REMU);
      end
`endif
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
`ifdef MC_ALU_DIV_EN
  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
